// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Register file with registered bypassed read ports, one write
//               port and a write-pending scoreboard driving RAW/WAW interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int  WIDTH   = 16,
    parameter int  NREGS   = 8,
    parameter int  NREAD   = 2,
    parameter int  ZERO_R0 = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    input  logic [NREAD-1:0]       rd_use,
    output logic [NREAD*WIDTH-1:0] rd_data,
    input  logic                   issue_valid,
    input  logic                   issue_wr,
    input  logic [AW-1:0]          issue_dest,
    output logic                   issue_stall,
    output logic                   issue_fire,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [NREGS-1:0]       busy
);

    localparam bit c_ZERO = (ZERO_R0 != 0);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_fire;

    logic [NREAD-1:0] w_src_haz;
    logic             w_dst_haz;
    logic             w_accept;
    logic             w_wr_keep;
    logic [NREGS-1:0] w_busy_next;

    // Addresses beyond NREGS (non power-of-two sizes) read as idle registers.
    function automatic logic busy_at(input logic [AW-1:0] addr);
        if (int'(addr) < NREGS) begin
            return r_busy[addr];
        end
        return 1'b0;
    endfunction

    function automatic logic wr_hit(input logic [AW-1:0] addr);
        return wr_en && (wr_addr == addr);
    endfunction

    genvar k;
    generate
        for (k = 0; k < NREAD; k++) begin : g_rd
            logic [AW-1:0]    w_addr;
            logic [WIDTH-1:0] w_next;
            logic [WIDTH-1:0] r_data;

            assign w_addr       = rd_addr[k*AW +: AW];
            assign w_src_haz[k] = rd_use[k] && busy_at(w_addr) && !wr_hit(w_addr);

            always_comb begin
                w_next = '0;
                if (c_ZERO && (w_addr == '0)) begin
                    w_next = '0;
                end else if (wr_hit(w_addr)) begin
                    w_next = wr_data;
                end else if (int'(w_addr) < NREGS) begin
                    w_next = r_regs[w_addr];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_data <= '0;
                end else begin
                    r_data <= w_next;
                end
            end

            assign rd_data[k*WIDTH +: WIDTH] = r_data;
        end
    endgenerate

    assign w_dst_haz   = issue_wr && busy_at(issue_dest) && !wr_hit(issue_dest);
    assign issue_stall = issue_valid && ((|w_src_haz) || w_dst_haz);
    assign w_accept    = issue_valid && !issue_stall;
    assign w_wr_keep   = wr_en && !(c_ZERO && (wr_addr == '0)) && (int'(wr_addr) < NREGS);

    // Set is applied after clear so a new producer wins over the retiring write.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
            if (w_accept && issue_wr && (issue_dest == AW'(i)) && !(c_ZERO && (i == 0))) begin
                w_busy_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_keep) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_fire <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_fire <= w_accept;
        end
    end

    assign busy       = r_busy;
    assign issue_fire = r_fire;

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with a built-in write-pending scoreboard. It is the operand-fetch core of the decode stage. It provides `NREAD` registered read ports with write-to-read bypass, one write port from writeback, and a hazard check. The hazard check stalls issue while a source or destination register still has a write in flight. It generalises the fixed 8×16, 2-read register file and adds reset clearing, an optional hardwired-zero r0, and RAW/WAW interlock.

## Interface
Parameters:
- `WIDTH`, 16, data width of each register.
- `NREGS`, 8, number of registers; `AW = $clog2(NREGS)`; `NREGS` must be ≥ 2.
- `NREAD`, 2, number of read ports (1..4).
- `ZERO_R0`, 0. When 1, register 0 always reads 0, ignores writes, and is never marked busy.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-high; clears all registers, busy bits and outputs.
- `rd_addr`  in  NREAD*AW  read source addresses; port k is bits [k*AW +: AW].
- `rd_use`  in  NREAD  port k source is actually needed by the instruction (gates the hazard check).
- `rd_data`  out  NREAD*WIDTH  registered read data; port k is bits [k*WIDTH +: WIDTH].
- `issue_valid`  in  1  decoder presents an instruction this cycle.
- `issue_wr`  in  1  the presented instruction writes a register.
- `issue_dest`  in  AW  destination register of the presented instruction.
- `issue_stall`  out  1  combinational; instruction not accepted this cycle.
- `issue_fire`  out  1  registered; pulses the cycle `rd_data` belongs to an accepted instruction.
- `wr_en`  in  1  writeback write strobe.
- `wr_addr`  in  AW  writeback target.
- `wr_data`  in  WIDTH  writeback value.
- `busy`  out  NREGS  registered scoreboard; bit i set means a write to register i is pending.

## Operation
Write port:
- On a rising edge with `wr_en`, `regs[wr_addr] <= wr_data`.
- The same edge clears `busy[wr_addr]`.
- When `ZERO_R0=1` and `wr_addr==0`, the write is dropped.

Read ports:
- Each edge, `rd_data[k] <= (wr_en && wr_addr==rd_addr[k]) ? wr_data : regs[rd_addr[k]]`. This is the bypass.
- When `ZERO_R0=1` and `rd_addr[k]==0`, the port reads 0, with or without bypass.

Hazard:
- `src_haz[k] = rd_use[k] && busy[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k])`. A same-cycle writeback resolves the hazard.
- `dst_haz = issue_wr && busy[issue_dest] && !(wr_en && wr_addr==issue_dest)`.
- `issue_stall = issue_valid && (|src_haz || dst_haz)`.

Accept:
- `accept = issue_valid && !issue_stall`.
- On accept with `issue_wr`, set `busy[issue_dest]`. This is skipped for r0 when `ZERO_R0=1`.
- `issue_fire <= accept`.

Simultaneous events:
- Set and clear of the same busy bit on one edge: **set wins**. The new producer is pending, and the old write still lands in `regs`.
- Writes to different registers in the same cycle are independent.
- Register 0 is an ordinary register when `ZERO_R0=0`.

## Timing
- Read latency is 1 cycle: address at edge N-1 gives `rd_data` valid after edge N, aligned with `issue_fire`.
- Write-to-read: a write at edge N is visible on a read sampled at edge N via the bypass. There are no dead cycles.
- Scoreboard set-to-stall: an instruction accepted at edge N stalls a dependent instruction presented in cycle N+1.
- `issue_stall` is a pure combinational function of current inputs and `busy`. It has no dependency on `issue_fire` or `rd_data`.
- Reset values (immediate, asynchronous): all `regs` = 0, `busy` = 0, `rd_data` = 0, `issue_fire` = 0. Reset mid-operation drops every pending write without restore.
- First edge after reset release: normal operation; no warm-up cycle.

## Test plan
- **Reset/readback:** assert `reset` mid-run after writing r3=16'h1234. Then read r3 and r1 → `rd_data` = 0/0, `busy` = 0, `issue_fire` = 0 during and after reset.
- **Bypass:** `wr_en`, r5 ← 16'hBEEF while `rd_addr` = {r5, r5} on the same edge → next cycle both ports = 16'hBEEF. Without `wr_en`, the previous value is returned.
- **RAW interlock:**
  - Issue dest r2 (accepted, `busy[2]`=1).
  - Next cycle, present source r2 with `rd_use` → `issue_stall`=1 until `wr_en` to r2 arrives. That cycle gives stall=0, `issue_fire` next cycle, and `rd_data` = the written value.
- **WAW + set-wins:**
  - With `busy[4]` set, issue dest r4 → stall.
  - Repeat in the cycle `wr_en` hits r4 → accepted, `busy[4]` stays 1.
- **ZERO_R0=1:**
  - Write r0 ← 16'hFFFF, then read r0 → 0.
  - Issue dest r0 → no busy bit, no stall.
  - A source r0 never stalls.
- **Parameter sweep:** WIDTH=32, NREGS=16, NREAD=3.
  - Write r15 ← 32'hDEADBEEF.
  - Read r15 on all three ports → all return it.
  - `rd_use`=0 on a busy source → no stall.
